// File: rtl/fp_pkg.sv
// Shared definitions for the FP add/sub operand path.
//  - Single and double precision width defaults.
//  - Exponent all-ones / all-zeros constants, sized for the widest format;
//    users slice the low W_Exp bits.
//  - State encoding for the unpack phase FSM.
package fp_pkg;

    localparam int W_SP     = 32;
    localparam int W_EXP_SP = 8;
    localparam int W_SGF_SP = 23;

    localparam int W_DP     = 64;
    localparam int W_EXP_DP = 11;
    localparam int W_SGF_DP = 52;

    localparam logic [W_EXP_DP-1:0] EXP_ONES = '1;
    localparam logic [W_EXP_DP-1:0] EXP_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLASSIFY = 2'd1,
        COMPARE  = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/ieee_classify.sv
// Combinational field split and special-value classification of one
// IEEE-754 word.
//  word      : operand
//  sign      : sign bit
//  exp_eff   : biased exponent, denormals reported as 1
//  sgf_ext   : significand with hidden bit restored at the MSB
//  is_nan / is_inf / is_zero / is_denorm : class flags
// Build option FP_DENORM_FLUSH_EN: denormals are flushed to signed zero
// (exp_eff=0, sgf_ext=0, is_zero=1); otherwise they pass through.
module ieee_classify
    import fp_pkg::*;
#(
    parameter int W     = W_SP,
    parameter int W_Exp = W_EXP_SP,
    parameter int W_Sgf = W_SGF_SP
) (
    input  logic [W-1:0]     word,
    output logic             sign,
    output logic [W_Exp-1:0] exp_eff,
    output logic [W_Sgf:0]   sgf_ext,
    output logic             is_nan,
    output logic             is_inf,
    output logic             is_zero,
    output logic             is_denorm
);

    logic [W_Exp-1:0] w_exp;
    logic [W_Sgf-1:0] w_sgf;
    logic             w_exp_ones;
    logic             w_exp_zero;
    logic             w_sgf_zero;

    assign sign       = word[W-1];
    assign w_exp      = word[W-2 -: W_Exp];
    assign w_sgf      = word[W_Sgf-1:0];
    assign w_exp_ones = (w_exp == EXP_ONES[W_Exp-1:0]);
    assign w_exp_zero = (w_exp == EXP_ZERO[W_Exp-1:0]);
    assign w_sgf_zero = (w_sgf == '0);

    assign is_nan    = w_exp_ones & ~w_sgf_zero;
    assign is_inf    = w_exp_ones &  w_sgf_zero;
    assign is_denorm = w_exp_zero & ~w_sgf_zero;

`ifdef FP_DENORM_FLUSH_EN
    assign exp_eff = w_exp;
    assign sgf_ext = w_exp_zero ? '0 : {1'b1, w_sgf};
    assign is_zero = w_exp_zero;
`else
    // Denormals share the scale of exponent 1, so report that exponent and
    // rely on the cleared hidden bit to keep them below the normals.
    assign exp_eff = is_denorm ? {{(W_Exp-1){1'b0}}, 1'b1} : w_exp;
    assign sgf_ext = {~w_exp_zero, w_sgf};
    assign is_zero = w_exp_zero & w_sgf_zero;
`endif

endmodule

// File: rtl/ieee_unpack_phase.sv
// Operand-intake stage of the FP add/sub pipeline.
// Captures two IEEE operands, classifies them, orders them by magnitude
// (M = larger, m = smaller) and holds registered fields for alignment.
//  clk, rst (async, active-low)
//  in_valid/in_ready, op_a, op_b      : operand handshake
//  out_valid/out_ready                : result handshake
//  sgn_*, exp_*, sgf_*, exp_diff, swap : ordered fields
//  nan_o, inf_o, zero_o               : special-value flags
// Build option FP_DENORM_FLUSH_EN (see ieee_classify).
//
// state    | meaning
// IDLE     | in_ready=1, capture operands on in_valid
// CLASSIFY | split and classify captured operands
// COMPARE  | magnitude order, register outputs
// DONE     | out_valid=1, hold until out_ready
module ieee_unpack_phase
    import fp_pkg::*;
#(
    parameter int W     = W_SP,
    parameter int W_Exp = W_EXP_SP,
    parameter int W_Sgf = W_SGF_SP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sgn_M,
    output logic             sgn_m,
    output logic [W_Exp-1:0] exp_M,
    output logic [W_Exp-1:0] exp_m,
    output logic [W_Sgf:0]   sgf_M,
    output logic [W_Sgf:0]   sgf_m,
    output logic [W_Exp-1:0] exp_diff,
    output logic             swap,
    output logic             nan_o,
    output logic             inf_o,
    output logic             zero_o
);

    state_t r_state, w_state_nxt;

    logic [W-1:0]     r_op_a, r_op_b;
    logic             r_a_sgn, r_b_sgn;
    logic [W_Exp-1:0] r_a_exp, r_b_exp;
    logic [W_Sgf:0]   r_a_sgf, r_b_sgf;
    logic             r_nan, r_inf, r_zero;

    logic             r_sgn_M, r_sgn_m, r_swap, r_nan_o, r_inf_o, r_zero_o;
    logic [W_Exp-1:0] r_exp_M, r_exp_m, r_exp_diff;
    logic [W_Sgf:0]   r_sgf_M, r_sgf_m;

    logic             w_a_sgn, w_b_sgn;
    logic [W_Exp-1:0] w_a_exp, w_b_exp;
    logic [W_Sgf:0]   w_a_sgf, w_b_sgf;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic             w_a_zero, w_b_zero, w_a_denorm, w_b_denorm;
    logic             w_unused;
    logic             w_swap;
    logic             w_nan;

    ieee_classify #(.W(W), .W_Exp(W_Exp), .W_Sgf(W_Sgf)) u_cls_a (
        .word      (r_op_a),
        .sign      (w_a_sgn),
        .exp_eff   (w_a_exp),
        .sgf_ext   (w_a_sgf),
        .is_nan    (w_a_nan),
        .is_inf    (w_a_inf),
        .is_zero   (w_a_zero),
        .is_denorm (w_a_denorm)
    );

    ieee_classify #(.W(W), .W_Exp(W_Exp), .W_Sgf(W_Sgf)) u_cls_b (
        .word      (r_op_b),
        .sign      (w_b_sgn),
        .exp_eff   (w_b_exp),
        .sgf_ext   (w_b_sgf),
        .is_nan    (w_b_nan),
        .is_inf    (w_b_inf),
        .is_zero   (w_b_zero),
        .is_denorm (w_b_denorm)
    );

    // Denormal status is already folded into the fields; nothing here needs it.
    assign w_unused = w_a_denorm | w_b_denorm;

    assign w_nan  = w_a_nan | w_b_nan;
    // Exponent above significand makes a plain unsigned compare a magnitude compare.
    assign w_swap = {r_b_exp, r_b_sgf} > {r_a_exp, r_a_sgf};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = CLASSIFY;
            end
            CLASSIFY: w_state_nxt = COMPARE;
            COMPARE:  w_state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_a_sgn    <= 1'b0;
            r_b_sgn    <= 1'b0;
            r_a_exp    <= '0;
            r_b_exp    <= '0;
            r_a_sgf    <= '0;
            r_b_sgf    <= '0;
            r_nan      <= 1'b0;
            r_inf      <= 1'b0;
            r_zero     <= 1'b0;
            r_sgn_M    <= 1'b0;
            r_sgn_m    <= 1'b0;
            r_exp_M    <= '0;
            r_exp_m    <= '0;
            r_sgf_M    <= '0;
            r_sgf_m    <= '0;
            r_exp_diff <= '0;
            r_swap     <= 1'b0;
            r_nan_o    <= 1'b0;
            r_inf_o    <= 1'b0;
            r_zero_o   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op_a <= op_a;
                        r_op_b <= op_b;
                    end
                end
                CLASSIFY: begin
                    r_a_sgn <= w_a_sgn;
                    r_b_sgn <= w_b_sgn;
                    r_a_exp <= w_a_exp;
                    r_b_exp <= w_b_exp;
                    r_a_sgf <= w_a_sgf;
                    r_b_sgf <= w_b_sgf;
                    r_nan   <= w_nan;
                    r_inf   <= (w_a_inf | w_b_inf) & ~w_nan;
                    r_zero  <= w_a_zero & w_b_zero;
                end
                COMPARE: begin
                    r_swap     <= w_swap;
                    r_sgn_M    <= w_swap ? r_b_sgn : r_a_sgn;
                    r_sgn_m    <= w_swap ? r_a_sgn : r_b_sgn;
                    r_exp_M    <= w_swap ? r_b_exp : r_a_exp;
                    r_exp_m    <= w_swap ? r_a_exp : r_b_exp;
                    r_sgf_M    <= w_swap ? r_b_sgf : r_a_sgf;
                    r_sgf_m    <= w_swap ? r_a_sgf : r_b_sgf;
                    r_exp_diff <= w_swap ? (r_b_exp - r_a_exp) : (r_a_exp - r_b_exp);
                    r_nan_o    <= r_nan;
                    r_inf_o    <= r_inf;
                    r_zero_o   <= r_zero;
                end
                default: ;
            endcase
        end
    end

    assign sgn_M    = r_sgn_M;
    assign sgn_m    = r_sgn_m;
    assign exp_M    = r_exp_M;
    assign exp_m    = r_exp_m;
    assign sgf_M    = r_sgf_M;
    assign sgf_m    = r_sgf_m;
    assign exp_diff = r_exp_diff;
    assign swap     = r_swap;
    assign nan_o    = r_nan_o;
    assign inf_o    = r_inf_o;
    assign zero_o   = r_zero_o;

endmodule

// File: tb/tb_ieee_unpack_phase.sv
module tb_ieee_unpack_phase;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a, op_b;
    logic        out_valid;
    logic        out_ready;
    logic        sgn_M, sgn_m;
    logic [7:0]  exp_M, exp_m, exp_diff;
    logic [23:0] sgf_M, sgf_m;
    logic        swap, nan_o, inf_o, zero_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ieee_unpack_phase dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sgn_M     (sgn_M),
        .sgn_m     (sgn_m),
        .exp_M     (exp_M),
        .exp_m     (exp_m),
        .sgf_M     (sgf_M),
        .sgf_m     (sgf_m),
        .exp_diff  (exp_diff),
        .swap      (swap),
        .nan_o     (nan_o),
        .inf_o     (inf_o),
        .zero_o    (zero_o)
    );

    // Present one pair, return number of edges from accept to out_valid (bounded).
    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_total++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_hs got %b want 10", {in_ready, out_valid});
        else n_pass++;
        n_total++;
        if ({sgn_M, sgn_m, swap, nan_o, inf_o, zero_o, exp_M, exp_m, exp_diff, sgf_M, sgf_m} !== '0)
            $display("FAIL reset_fields got exp_M=%h sgf_M=%h swap=%b", exp_M, sgf_M, swap);
        else n_pass++;
    endtask

    task automatic test_basic_order();
        int lat;
        send_pair(32'h4040_0000, 32'h3F80_0000, lat);
        n_total++;
        if (lat !== 3) $display("FAIL t1_latency got %0d want 3", lat); else n_pass++;
        n_total++;
        if ({sgn_M, sgn_m, swap, nan_o, inf_o, zero_o} !== 6'b000000)
            $display("FAIL t1_flags got %b want 000000", {sgn_M, sgn_m, swap, nan_o, inf_o, zero_o});
        else n_pass++;
        n_total++;
        if ({exp_M, exp_m, exp_diff} !== {8'h80, 8'h7F, 8'h01})
            $display("FAIL t1_exp got %h %h %h want 80 7f 01", exp_M, exp_m, exp_diff);
        else n_pass++;
        n_total++;
        if ({sgf_M, sgf_m} !== {24'hC00000, 24'h800000})
            $display("FAIL t1_sgf got %h %h want c00000 800000", sgf_M, sgf_m);
        else n_pass++;
        release_result();
        n_total++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL t1_release got %b want 10", {in_ready, out_valid});
        else n_pass++;
    endtask

    task automatic test_swap();
        int lat;
        send_pair(32'h3F80_0000, 32'hC040_0000, lat);
        n_total++;
        if ({sgn_M, sgn_m, swap} !== 3'b101) $display("FAIL t2_sign_swap got %b want 101", {sgn_M, sgn_m, swap});
        else n_pass++;
        n_total++;
        if ({exp_M, exp_m, exp_diff, sgf_M, sgf_m} !== {8'h80, 8'h7F, 8'h01, 24'hC00000, 24'h800000})
            $display("FAIL t2_fields got %h %h %h %h %h", exp_M, exp_m, exp_diff, sgf_M, sgf_m);
        else n_pass++;
        release_result();
        // Equal magnitudes must not swap; sign of A goes to M.
        send_pair(32'h3F80_0000, 32'hBF80_0000, lat);
        n_total++;
        if ({sgn_M, sgn_m, swap, exp_diff} !== {3'b010, 8'h00})
            $display("FAIL t2_equal got sM=%b sm=%b swap=%b diff=%h want 0 1 0 00", sgn_M, sgn_m, swap, exp_diff);
        else n_pass++;
        release_result();
    endtask

    task automatic test_specials();
        int lat;
        send_pair(32'h7FC0_0000, 32'h3F80_0000, lat);
        n_total++;
        if ({nan_o, inf_o, zero_o, swap} !== 4'b1000)
            $display("FAIL t3_nan_flags got %b want 1000", {nan_o, inf_o, zero_o, swap});
        else n_pass++;
        n_total++;
        if ({exp_M, exp_diff, sgf_M} !== {8'hFF, 8'h80, 24'hC00000})
            $display("FAIL t3_nan_fields got %h %h %h want ff 80 c00000", exp_M, exp_diff, sgf_M);
        else n_pass++;
        release_result();
        send_pair(32'h7F80_0000, 32'h3F80_0000, lat);
        n_total++;
        if ({nan_o, inf_o, zero_o, swap} !== 4'b0100)
            $display("FAIL t3_inf_flags got %b want 0100", {nan_o, inf_o, zero_o, swap});
        else n_pass++;
        n_total++;
        if ({exp_M, exp_diff, sgf_M} !== {8'hFF, 8'h80, 24'h800000})
            $display("FAIL t3_inf_fields got %h %h %h want ff 80 800000", exp_M, exp_diff, sgf_M);
        else n_pass++;
        release_result();
        // NaN beats infinity.
        send_pair(32'h7F80_0000, 32'hFFC0_0000, lat);
        n_total++;
        if ({nan_o, inf_o} !== 2'b10) $display("FAIL t3_nan_over_inf got %b want 10", {nan_o, inf_o});
        else n_pass++;
        release_result();
    endtask

    task automatic test_denorm();
        int lat;
        send_pair(32'h0000_0001, 32'h0000_0000, lat);
`ifdef FP_DENORM_FLUSH_EN
        n_total++;
        if ({zero_o, swap, exp_M, sgf_M, exp_diff} !== {2'b10, 8'h00, 24'h000000, 8'h00})
            $display("FAIL t4_flush got zero=%b swap=%b exp_M=%h sgf_M=%h diff=%h", zero_o, swap, exp_M, sgf_M, exp_diff);
        else n_pass++;
`else
        n_total++;
        if ({zero_o, swap, exp_M, sgf_M} !== {2'b00, 8'h01, 24'h000001})
            $display("FAIL t4_denorm got zero=%b swap=%b exp_M=%h sgf_M=%h", zero_o, swap, exp_M, sgf_M);
        else n_pass++;
        n_total++;
        if ({exp_m, sgf_m, exp_diff} !== {8'h00, 24'h000000, 8'h01})
            $display("FAIL t4_denorm_m got exp_m=%h sgf_m=%h diff=%h want 00 000000 01", exp_m, sgf_m, exp_diff);
        else n_pass++;
`endif
        release_result();
        send_pair(32'h8000_0000, 32'h0000_0000, lat);
        n_total++;
        if (zero_o !== 1'b1) $display("FAIL t4_both_zero got %b want 1", zero_o); else n_pass++;
        release_result();
    endtask

    task automatic test_stall();
        int lat;
        send_pair(32'h4040_0000, 32'h3F80_0000, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op_a     = 32'h7F80_0000;
            op_b     = 32'h4100_0000;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            n_total++;
            if ({in_ready, out_valid, swap, nan_o, inf_o, exp_M, exp_m, exp_diff, sgf_M, sgf_m} !==
                {2'b01, 3'b000, 8'h80, 8'h7F, 8'h01, 24'hC00000, 24'h800000})
                $display("FAIL t5_hold cycle %0d got rdy=%b vld=%b exp_M=%h sgf_M=%h", i, in_ready, out_valid, exp_M, sgf_M);
            else n_pass++;
        end
        in_valid = 1'b0;
        release_result();
        n_total++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL t5_release got %b want 10", {in_ready, out_valid});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        op_a     = 32'hC120_0000;
        op_b     = 32'h4000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL t6_busy got in_ready=%b want 0", in_ready); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_total++;
        if ({in_ready, out_valid, exp_M, sgf_M, exp_diff, sgn_M} !== {2'b10, 41'd0})
            $display("FAIL t6_abort got rdy=%b vld=%b exp_M=%h sgf_M=%h", in_ready, out_valid, exp_M, sgf_M);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        send_pair(32'h3F80_0000, 32'hC120_0000, lat);
        n_total++;
        if (lat !== 3) $display("FAIL t6_latency got %0d want 3", lat); else n_pass++;
        n_total++;
        if ({sgn_M, sgn_m, swap, exp_M, exp_m, exp_diff, sgf_M, sgf_m} !==
            {3'b101, 8'h82, 8'h7F, 8'h03, 24'hA00000, 24'h800000})
            $display("FAIL t6_after got %b%b%b %h %h %h %h %h", sgn_M, sgn_m, swap, exp_M, exp_m, exp_diff, sgf_M, sgf_m);
        else n_pass++;
        release_result();
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        #23;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        test_basic_order();
        test_swap();
        test_specials();
        test_denorm();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
